hazard_scoreboard: RTL and testbench

- Parametrised scoreboard-based hazard unit for the in-order pipeline; replaces per-stage register-compare stall logic.
- Tracks every architectural register with a pending-write countdown. Stalls decode on RAW/WAW against in-flight writers.
- Generates a multi-cycle fetch flush on PC redirect and keeps a saturating stall-cycle counter.
- Sits beside the IF/ID register; decode supplies operand/destination indices pre-decoded (R7 for JAL/JALR, Rs for STU/LBI/SLBI, Rd read for ST/STU).

---
 rtl/hazard_scoreboard.sv | 109 ++++++++++
 tb/tb_hazard_scoreboard.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register pending-write countdowns, decode stall, fetch flush.
// Define HAZ_FWD_EN when the forwarding network exists (RAW stalls only for load-use).
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned REG_W        = 3,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned WB_LAT       = 3,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_idx,
  input  logic [NUM_SRC-1:0]       src_vld,
  input  logic [REG_W-1:0]         dst_idx,
  input  logic                     dst_vld,
  input  logic                     dst_is_load,
  input  logic                     redirect,
  output logic                     stall_decode,
  output logic                     flush_fetch,
  output logic                     issue,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [15:0]              stall_cnt
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int unsigned SCNT_W = 16;

  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [NUM_REGS-1:0] ld;
  logic [FCNT_W-1:0] fcnt;
  logic              raw_haz;
  logic              waw_haz;
  logic              hazard;

  // Source compares use pre-edge counts, so an instruction never stalls on itself.
  always_comb begin
    raw_haz = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (src_vld[k]) begin
`ifdef HAZ_FWD_EN
        if (ld[src_idx[k*REG_W +: REG_W]] &&
            (cnt[src_idx[k*REG_W +: REG_W]] == CNT_W'(WB_LAT)))
          raw_haz = 1'b1;
`else
        if (cnt[src_idx[k*REG_W +: REG_W]] != '0)
          raw_haz = 1'b1;
`endif
      end
    end
    waw_haz = dst_vld && (cnt[dst_idx] != '0);
    hazard  = id_valid && (raw_haz || waw_haz);
  end

`ifndef HAZ_FWD_EN
  logic unused_ld;
  assign unused_ld = ^ld;
`endif

  // Redirect wins over a hazard: the decode instruction is squashed anyway.
  assign stall_decode = hazard && !redirect;
  assign issue        = id_valid && !hazard && !redirect && (fcnt == '0);
  assign flush_fetch  = redirect || (fcnt != '0);

  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      busy_vec[r] = (cnt[r] != '0);
  end

  // Countdowns tick every edge; a new writer reloads its destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      ld <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (issue && dst_vld && (dst_idx == REG_W'(r))) begin
          cnt[r] <= CNT_W'(WB_LAT);
          ld[r]  <= dst_is_load;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
          if (cnt[r] == CNT_W'(1))
            ld[r] <= 1'b0;
        end
      end
    end
  end

  // Flush window restarts on every redirect rather than accumulating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fcnt <= '0;
    else if (redirect)
      fcnt <= FCNT_W'(FLUSH_CYCLES);
    else if (fcnt != '0)
      fcnt <= fcnt - FCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_decode && (stall_cnt != '1))
      stall_cnt <= stall_cnt + SCNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, mid-run reset, randomized model check.
module tb_hazard_scoreboard;

  localparam int unsigned NR = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned NS = 3;
  localparam int unsigned WB = 3;
  localparam int unsigned FC = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           id_valid;
  logic [NS*RW-1:0] src_idx;
  logic [NS-1:0]  src_vld;
  logic [RW-1:0]  dst_idx;
  logic           dst_vld, dst_is_load, redirect;
  logic           stall_decode, flush_fetch, issue;
  logic [NR-1:0]  busy_vec;
  logic [15:0]    stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_idx(src_idx),
    .src_vld(src_vld), .dst_idx(dst_idx), .dst_vld(dst_vld),
    .dst_is_load(dst_is_load), .redirect(redirect),
    .stall_decode(stall_decode), .flush_fetch(flush_fetch), .issue(issue),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] s0, s1, s2;
    logic [2:0] sv;
    logic [2:0] d;
    logic       dv, dl, rd;
    logic       e_stall, e_issue, e_flush;
    logic [7:0] e_busy;
    logic [15:0] e_scnt;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic v, input logic [2:0] s0, s1, s2, sv, d,
                     input logic dv, dl, rd, es, ei, ef,
                     input logic [7:0] eb, input logic [15:0] ec);
    vec_t t;
    t.v = v; t.s0 = s0; t.s1 = s1; t.s2 = s2; t.sv = sv; t.d = d;
    t.dv = dv; t.dl = dl; t.rd = rd; t.e_stall = es; t.e_issue = ei;
    t.e_flush = ef; t.e_busy = eb; t.e_scnt = ec;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s0, s1, s2, sv, d,
                       input logic dv, dl, rd);
    id_valid = v; src_idx = {s2, s1, s0}; src_vld = sv;
    dst_idx = d; dst_vld = dv; dst_is_load = dl; redirect = rd;
  endtask

  // Reference model: timestamps of when each register becomes readable.
  longint now;
  longint ready [NR];
  bit     isld  [NR];
  longint last_rd;
  bit     rd_seen;
  int     mscnt;
  logic   m_stall, m_issue, m_flush;
  logic [7:0] m_busy;

  function automatic longint remaining(input int r);
    return (ready[r] > now) ? ready[r] - now : 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < int'(NR); r++) begin ready[r] = 0; isld[r] = 0; end
    rd_seen = 0; last_rd = 0; mscnt = 0;
  endtask

  task automatic model_eval();
    bit raw, waw, haz, in_flush;
    int s;
    raw = 0;
    for (int k = 0; k < int'(NS); k++) begin
      s = int'(src_idx[k*RW +: RW]);
      if (src_vld[k]) begin
`ifdef HAZ_FWD_EN
        if (isld[s] && remaining(s) == longint'(WB)) raw = 1;
`else
        if (remaining(s) != 0) raw = 1;
`endif
      end
    end
    waw = dst_vld && (remaining(int'(dst_idx)) != 0);
    haz = id_valid && (raw || waw);
    in_flush = rd_seen && (now - last_rd >= 1) && (now - last_rd <= longint'(FC));
    m_stall = haz && !redirect;
    m_issue = id_valid && !haz && !redirect && !in_flush;
    m_flush = redirect || in_flush;
    for (int r = 0; r < int'(NR); r++) m_busy[r] = (remaining(r) != 0);
  endtask

  task automatic model_step();
    if (m_issue && dst_vld) begin
      ready[int'(dst_idx)] = now + 1 + longint'(WB);
      isld[int'(dst_idx)]  = dst_is_load;
    end
    if (m_stall && mscnt < 65535) mscnt++;
    if (redirect) begin last_rd = now; rd_seen = 1; end
    now++;
  endtask

  task automatic model_cycle(input string tag);
    model_eval();
    @(negedge clk);
    chk({tag, " stall"}, 32'(stall_decode), 32'(m_stall));
    chk({tag, " issue"}, 32'(issue), 32'(m_issue));
    chk({tag, " flush"}, 32'(flush_fetch), 32'(m_flush));
    chk({tag, " busy"},  32'(busy_vec), 32'(m_busy));
    chk({tag, " scnt"},  32'(stall_cnt), 32'(mscnt));
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    now = 0;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst stall", 32'(stall_decode), 32'd0);
    chk("rst issue", 32'(issue), 32'd0);
    chk("rst flush", 32'(flush_fetch), 32'd0);
    chk("rst busy",  32'(busy_vec), 32'd0);
    chk("rst scnt",  32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef HAZ_FWD_EN
    //   v s0 s1 s2 sv     d  dv dl rd  stl iss fl busy   scnt
    row(1, 0, 0, 0, 3'b000, 4, 1, 1, 0,  0, 1, 0, 8'h00, 0);  // LD r4
    row(1, 4, 0, 0, 3'b001, 6, 1, 0, 0,  1, 0, 0, 8'h10, 0);  // load-use bubble
    row(1, 4, 0, 0, 3'b001, 6, 1, 0, 0,  0, 1, 0, 8'h10, 1);
    row(1, 0, 0, 0, 3'b000, 5, 1, 0, 0,  0, 1, 0, 8'h50, 1);  // ADD r5
    row(1, 5, 0, 0, 3'b001, 0, 0, 0, 0,  0, 1, 0, 8'h60, 1);  // forwarded reader
    row(1, 0, 0, 0, 3'b000, 5, 1, 0, 0,  1, 0, 0, 8'h60, 1);  // WAW on r5
    row(1, 0, 0, 0, 3'b000, 5, 1, 0, 0,  1, 0, 0, 8'h20, 2);
    row(1, 0, 0, 0, 3'b000, 5, 1, 0, 0,  0, 1, 0, 8'h00, 3);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h20, 3);
`else
    //   v s0 s1 s2 sv     d  dv dl rd  stl iss fl busy   scnt
    row(1, 2, 3, 0, 3'b011, 1, 1, 0, 0,  0, 1, 0, 8'h00, 0);  // ADD r1<-r2,r3
    row(1, 1, 0, 0, 3'b001, 4, 1, 0, 0,  1, 0, 0, 8'h02, 0);  // reader of r1
    row(1, 1, 0, 0, 3'b001, 4, 1, 0, 0,  1, 0, 0, 8'h02, 1);
    row(1, 1, 0, 0, 3'b001, 4, 1, 0, 0,  1, 0, 0, 8'h02, 2);
    row(1, 1, 0, 0, 3'b001, 4, 1, 0, 0,  0, 1, 0, 8'h00, 3);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h10, 3);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h10, 3);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h10, 3);
    row(1, 0, 0, 0, 3'b000, 7, 1, 0, 0,  0, 1, 0, 8'h00, 3);  // JAL -> r7
    row(1, 7, 1, 0, 3'b011, 0, 0, 0, 0,  1, 0, 0, 8'h80, 3);  // ST data r7
    row(1, 7, 1, 0, 3'b011, 0, 0, 0, 0,  1, 0, 0, 8'h80, 4);
    row(1, 7, 1, 0, 3'b011, 0, 0, 0, 0,  1, 0, 0, 8'h80, 5);
    row(1, 7, 1, 0, 3'b011, 0, 0, 0, 0,  0, 1, 0, 8'h00, 6);
    row(1, 0, 0, 0, 3'b000, 1, 1, 0, 0,  0, 1, 0, 8'h00, 6);  // independent r1,r2,r3
    row(1, 0, 0, 0, 3'b000, 2, 1, 0, 0,  0, 1, 0, 8'h02, 6);
    row(1, 0, 0, 0, 3'b000, 3, 1, 0, 0,  0, 1, 0, 8'h06, 6);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h0E, 6);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h0C, 6);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h08, 6);
    row(1, 0, 0, 0, 3'b000, 5, 1, 0, 0,  0, 1, 0, 8'h00, 6);  // ADD r5
    row(1, 5, 0, 0, 3'b001, 0, 0, 0, 1,  0, 0, 1, 8'h20, 6);  // hazard + redirect
    row(1, 5, 0, 0, 3'b001, 0, 0, 0, 0,  1, 0, 1, 8'h20, 6);
    row(1, 5, 0, 0, 3'b001, 0, 0, 0, 0,  1, 0, 1, 8'h20, 7);
    row(1, 5, 0, 0, 3'b001, 0, 0, 0, 0,  0, 1, 0, 8'h00, 8);
    row(0, 0, 0, 0, 3'b000, 0, 0, 0, 0,  0, 0, 0, 8'h00, 8);
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].sv,
            tbl[i].d, tbl[i].dv, tbl[i].dl, tbl[i].rd);
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), 32'(stall_decode), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d issue", i), 32'(issue), 32'(tbl[i].e_issue));
      chk($sformatf("vec%0d flush", i), 32'(flush_fetch), 32'(tbl[i].e_flush));
      chk($sformatf("vec%0d busy", i),  32'(busy_vec), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d scnt", i),  32'(stall_cnt), 32'(tbl[i].e_scnt));
      @(posedge clk); #1;
    end

    // Clean restart so the model and DUT start from identical state.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 1500; n++) begin
      drive(($urandom % 4) != 0,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), ($urandom % 12) == 0);
      model_cycle("rnd");
    end

    // Mid-cycle reset with r1,r2 pending.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 4; n++) model_cycle("drain");
    drive(1, 0, 0, 0, 3'b000, 1, 1, 0, 0);
    model_cycle("mr w1");
    drive(1, 0, 0, 0, 3'b000, 2, 1, 0, 0);
    model_cycle("mr w2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr busy pre", 32'(busy_vec), 32'h06);
    #1 rst_n = 1'b0;
    #1;
    chk("mr busy async", 32'(busy_vec), 32'h00);
    chk("mr scnt async", 32'(stall_cnt), 32'h0);
    chk("mr flush async", 32'(flush_fetch), 32'h0);
    model_reset();
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(1, 1, 2, 0, 3'b011, 3, 1, 0, 0);
    @(negedge clk);
    chk("mr reader stall", 32'(stall_decode), 32'd0);
    chk("mr reader issue", 32'(issue), 32'd1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mr after busy", 32'(busy_vec), 32'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
